// File: rtl/stream_pkg.sv
// stream_pkg: shared definitions for the 2:1 stream merge slice.
//   - DATA_W_DEFAULT : default payload width
//   - state_t        : merge FSM state encoding (IDLE, LOCK_A, LOCK_B)
//   - GRANT_A/GRANT_B: encoding of the last_grant register
package stream_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOCK_A = 2'b01,
        ST_LOCK_B = 2'b10
    } state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-requester round-robin arbiter (purely combinational).
//   req_a, req_b : request lines
//   last_grant   : requester served most recently (GRANT_A / GRANT_B)
//   gnt          : one-hot grant, gnt[0] = A, gnt[1] = B; 2'b00 when no request
module rr_arbiter_2
    import stream_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt = 2'b00;
        case ({req_b, req_a})
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last_grant == GRANT_A) begin
                    gnt = 2'b10;
                end else begin
                    gnt = 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/stream_merge_2to1.sv
// stream_merge_2to1: packet-aware 2:1 valid/ready stream merge.
//   clk, rst_n                       : clock, async active-low reset
//   s_a_valid/ready/data/last        : input channel A
//   s_b_valid/ready/data/last        : input channel B
//   m_valid/ready/data/last          : merged output channel (single register slot)
//   m_src                            : source of the current output beat (0 = A, 1 = B)
//   pkt_count                        : number of completed output packets (wraps)
// Once a multi-beat packet starts on one input, that input is locked in until
// its last beat is accepted, so packets are never interleaved on the output.
module stream_merge_2to1
    import stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_a_valid,
    output logic              s_a_ready,
    input  logic [DATA_W-1:0] s_a_data,
    input  logic              s_a_last,
    input  logic              s_b_valid,
    output logic              s_b_ready,
    input  logic [DATA_W-1:0] s_b_data,
    input  logic              s_b_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_src,
    output logic [15:0]       pkt_count
);

    state_t            state_r;
    state_t            state_next_s;
    logic              last_grant_r;
    logic              m_valid_r;
    logic [DATA_W-1:0] m_data_r;
    logic              m_last_r;
    logic              m_src_r;
    logic [15:0]       pkt_count_r;

    logic              slot_free_s;
    logic [1:0]        gnt_s;
    logic              a_ready_s;
    logic              b_ready_s;
    logic              acc_a_s;
    logic              acc_b_s;

    // The output slot can take a beat when it is empty or being drained now.
    assign slot_free_s = !m_valid_r || m_ready;

    rr_arbiter_2 u_arb (
        .req_a      (s_a_valid),
        .req_b      (s_b_valid),
        .last_grant (last_grant_r),
        .gnt        (gnt_s)
    );

    assign acc_a_s = s_a_valid && a_ready_s;
    assign acc_b_s = s_b_valid && b_ready_s;

    // FSM next state and input readies.
    always_comb begin
        state_next_s = state_r;
        a_ready_s    = 1'b0;
        b_ready_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                a_ready_s = slot_free_s && gnt_s[0];
                b_ready_s = slot_free_s && gnt_s[1];
            end
            ST_LOCK_A: begin
                a_ready_s = slot_free_s;
                b_ready_s = 1'b0;
            end
            ST_LOCK_B: begin
                a_ready_s = 1'b0;
                b_ready_s = slot_free_s;
            end
            default: begin
                a_ready_s = 1'b0;
                b_ready_s = 1'b0;
            end
        endcase

        // A last beat always releases to IDLE; a non-last beat (re)locks.
        if (acc_a_s) begin
            state_next_s = s_a_last ? ST_IDLE : ST_LOCK_A;
        end else if (acc_b_s) begin
            state_next_s = s_b_last ? ST_IDLE : ST_LOCK_B;
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_B;
        end else begin
            state_r <= state_next_s;
            if (acc_a_s) begin
                last_grant_r <= GRANT_A;
            end else if (acc_b_s) begin
                last_grant_r <= GRANT_B;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Output slot: load on accept, otherwise clear when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_W{1'b0}};
            m_last_r  <= 1'b0;
            m_src_r   <= 1'b0;
        end else if (acc_a_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= s_a_data;
            m_last_r  <= s_a_last;
            m_src_r   <= 1'b0;
        end else if (acc_b_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= s_b_data;
            m_last_r  <= s_b_last;
            m_src_r   <= 1'b1;
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    // Completed-packet counter, counts output handshakes of last beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_r <= 16'd0;
        end else if (m_valid_r && m_ready && m_last_r) begin
            pkt_count_r <= pkt_count_r + 16'd1;
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

    assign s_a_ready = a_ready_s;
    assign s_b_ready = b_ready_s;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign m_last    = m_last_r;
    assign m_src     = m_src_r;
    assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_stream_merge_2to1.sv
// Directed bench for stream_merge_2to1: hand-computed expectations checked
// with immediate assertions at each comparison point.
module tb_stream_merge_2to1;

    logic        clk;
    logic        rst_n;
    logic        s_a_valid;
    logic        s_a_ready;
    logic [7:0]  s_a_data;
    logic        s_a_last;
    logic        s_b_valid;
    logic        s_b_ready;
    logic [7:0]  s_b_data;
    logic        s_b_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_src;
    logic [15:0] pkt_count;

    int total;
    int passes;

    stream_merge_2to1 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_a_valid (s_a_valid),
        .s_a_ready (s_a_ready),
        .s_a_data  (s_a_data),
        .s_a_last  (s_a_last),
        .s_b_valid (s_b_valid),
        .s_b_ready (s_b_ready),
        .s_b_data  (s_b_data),
        .s_b_last  (s_b_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_src     (m_src),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        s_a_valid = 1'b0; s_a_data = 8'h00; s_a_last = 1'b0;
        s_b_valid = 1'b0; s_b_data = 8'h00; s_b_last = 1'b0;
        m_ready   = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_d [6];
    logic       exp_s [6];
    int         a_i;
    int         b_i;
    logic       acc_a;
    logic       acc_b;

    initial begin
        total  = 0;
        passes = 0;
        exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---- reset values ----
        rst_n     = 1'b0;
        s_a_valid = 1'b0; s_a_data = 8'h00; s_a_last = 1'b0;
        s_b_valid = 1'b0; s_b_data = 8'h00; s_b_last = 1'b0;
        m_ready   = 1'b1;
        #2;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_pkt", {16'd0, pkt_count}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("idle_no_ready", {30'd0, s_a_ready, s_b_ready}, 32'd0);

        // ---- A-only 1-beat packets 0x11, 0x22 ----
        s_a_valid = 1'b1; s_a_data = 8'h11; s_a_last = 1'b1;
        #1;
        check("a_ready_first", {31'd0, s_a_ready}, 32'd1);
        tick();
        check("a11_data", {24'd0, m_data}, 32'h11);
        check("a11_src", {31'd0, m_src}, 32'd0);
        check("a11_valid", {31'd0, m_valid}, 32'd1);
        s_a_data = 8'h22;
        tick();
        check("a22_data", {24'd0, m_data}, 32'h22);
        check("a22_pkt", {16'd0, pkt_count}, 32'd1);
        s_a_valid = 1'b0;
        tick();
        check("a_drain_valid", {31'd0, m_valid}, 32'd0);
        check("a_pkt2", {16'd0, pkt_count}, 32'd2);

        // ---- round robin A/B ties ----
        do_reset();
        a_i = 0;
        b_i = 0;
        for (int k = 0; k < 6; k++) begin
            s_a_valid = (a_i < 3); s_a_data = 8'hA0 + 8'(a_i); s_a_last = 1'b1;
            s_b_valid = (b_i < 3); s_b_data = 8'hB0 + 8'(b_i); s_b_last = 1'b1;
            #1;
            acc_a = s_a_valid && s_a_ready;
            acc_b = s_b_valid && s_b_ready;
            tick();
            check("rr_data", {24'd0, m_data}, {24'd0, exp_d[k]});
            check("rr_src", {31'd0, m_src}, {31'd0, exp_s[k]});
            if (acc_a) a_i++;
            if (acc_b) b_i++;
        end

        // ---- 3-beat A packet locks out B ----
        s_a_valid = 1'b1; s_a_data = 8'h01; s_a_last = 1'b0;
        s_b_valid = 1'b1; s_b_data = 8'hC0; s_b_last = 1'b1;
        #1;
        check("lock1_rdy", {30'd0, s_a_ready, s_b_ready}, 32'b10);
        tick();
        check("lock1_data", {24'd0, m_data}, 32'h01);
        s_a_data = 8'h02;
        #1;
        check("lock2_rdy", {30'd0, s_a_ready, s_b_ready}, 32'b10);
        tick();
        check("lock2_data", {24'd0, m_data}, 32'h02);
        s_a_data = 8'h03; s_a_last = 1'b1;
        #1;
        check("lock3_rdy", {30'd0, s_a_ready, s_b_ready}, 32'b10);
        tick();
        check("lock3_data", {25'd0, m_last, m_data}, 32'h103);
        s_a_valid = 1'b0;
        #1;
        check("unlock_b_rdy", {31'd0, s_b_ready}, 32'd1);
        tick();
        check("unlock_b_out", {23'd0, m_src, m_data}, 32'h1C0);
        s_b_valid = 1'b0;
        tick();
        check("drain_c0", {31'd0, m_valid}, 32'd0);

        // ---- backpressure hold ----
        s_a_valid = 1'b1; s_a_data = 8'h5A; s_a_last = 1'b1;
        m_ready = 1'b0;
        tick();
        s_a_data = 8'h66;
        s_b_valid = 1'b1; s_b_data = 8'h77; s_b_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("stall_data", {23'd0, m_valid, m_data}, 32'h15A);
            check("stall_rdy", {30'd0, s_a_ready, s_b_ready}, 32'd0);
            tick();
        end
        m_ready = 1'b1;
        #1;
        check("resume_b_rdy", {30'd0, s_a_ready, s_b_ready}, 32'b01);
        tick();
        check("resume_77", {23'd0, m_src, m_data}, 32'h177);
        s_b_valid = 1'b0;
        tick();
        check("resume_66", {23'd0, m_src, m_data}, 32'h066);
        s_a_valid = 1'b0;
        tick();
        check("pkt_after_stall", {16'd0, pkt_count}, 32'd11);

        // ---- pkt_count wrap ----
        do_reset();
        s_a_valid = 1'b1; s_a_data = 8'h33; s_a_last = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        s_a_valid = 1'b0;
        tick();
        check("pkt_ffff", {16'd0, pkt_count}, 32'hFFFF);
        s_a_valid = 1'b1;
        tick();
        s_a_valid = 1'b0;
        tick();
        check("pkt_wrap", {16'd0, pkt_count}, 32'd0);

        // ---- reset mid-packet in LOCK_B ----
        s_b_valid = 1'b1; s_b_data = 8'hB5; s_b_last = 1'b0;
        m_ready = 1'b0;
        tick();
        check("lockb_held", {23'd0, m_valid, m_data}, 32'h1B5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_data", {24'd0, m_data}, 32'd0);
        rst_n = 1'b1;
        s_a_valid = 1'b1; s_a_data = 8'hAA; s_a_last = 1'b1;
        s_b_valid = 1'b1; s_b_data = 8'hBB; s_b_last = 1'b1;
        m_ready = 1'b1;
        #1;
        check("post_rst_rdy", {30'd0, s_a_ready, s_b_ready}, 32'b10);
        tick();
        check("post_rst_out", {23'd0, m_src, m_data}, 32'h0AA);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/stream_merge_2to1.md
STREAM_MERGE_2TO1 -- requirements
Module: stream_merge_2to1

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width of both input channels and of the output channel.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 s_a_valid / s_a_ready / s_a_data / s_a_last  in / out / in[DATA_W] / in  SHALL be channel A, fed by demux output a.
REQ-005 s_b_valid / s_b_ready / s_b_data / s_b_last  in / out / in[DATA_W] / in  SHALL be channel B, fed by demux output b.
REQ-006 m_valid / m_ready / m_data / m_last  out / in / out[DATA_W] / out  SHALL be the merged output channel.
REQ-007 m_src  output  1  SHALL identify the source of the current output beat: 0 = A, 1 = B.
REQ-008 pkt_count  output  16  SHALL count completed output packets.

Function
REQ-009 A beat SHALL transfer on any channel only in a cycle where valid and ready are both 1 at the rising edge.
REQ-010 The output stage SHALL be a single register slot: slot_free = !m_valid || m_ready.
REQ-011 Latency from input handshake to m_valid SHALL be exactly 1 cycle; throughput SHALL be 1 beat/cycle when m_ready is held 1.
REQ-012 FSM states SHALL be IDLE, LOCK_A and LOCK_B.
REQ-013 In IDLE with slot_free, grant SHALL go to the single valid input, or, when both are valid, to the input not granted last (round-robin).
REQ-014 A granted beat with last=0 SHALL move the FSM to LOCK_A or LOCK_B; a beat with last=1 SHALL keep it in IDLE.
REQ-015 In LOCK_x, only input x SHALL be served; the other ready SHALL be 0; a beat with last=1 SHALL return the FSM to IDLE.
REQ-016 The last_grant register SHALL update on every granted beat.
REQ-017 s_x_ready SHALL be slot_free AND (granted in IDLE, or FSM in LOCK_x); it SHALL be 0 otherwise, including when neither input is valid.
REQ-018 While m_valid=1 and m_ready=0, m_data, m_last and m_src SHALL stay stable, and both input readies SHALL be 0.
REQ-019 m_valid SHALL clear on m_ready=1 when no new beat is accepted in the same cycle; a simultaneous drain and accept SHALL load the new beat with m_valid held at 1.
REQ-020 pkt_count SHALL increment by 1 on each output handshake with m_last=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-021 A lone 1-beat packet (last=1 on the first beat) SHALL be a complete packet and SHALL never enter LOCK.

Reset
REQ-022 While rst_n=0, the FSM SHALL be IDLE; m_valid, m_data, m_last, m_src and pkt_count SHALL be 0; last_grant SHALL be B, so A wins the first tie.
REQ-023 Reset asserted mid-packet SHALL discard the lock and any held output beat immediately; no completion of the partial packet is required.
REQ-024 After rst_n deasserts, the first grant SHALL be possible on the first rising edge.

Structure
REQ-025 The FSM state encodings, the GRANT_A/GRANT_B constants and the DATA_W default SHALL reside in shared package stream_pkg.
REQ-026 Round-robin selection SHALL be a sub-module, rr_arbiter_2 (inputs: two requests and last_grant; output: one-hot grant).

Verification
REQ-027 Bench SHALL drive reset, then A-only 1-beat packets 0x11, 0x22 with m_ready=1 -> outputs 0x11, 0x22 on consecutive cycles with m_src=0 and pkt_count=2.
REQ-028 Bench SHALL drive A and B both valid with 1-beat packets (A 0xA0..0xA2, B 0xB0..0xB2) -> output order A0 B0 A1 B1 A2 B2.
REQ-029 Bench SHALL start a 3-beat A packet (0x01, 0x02, 0x03 last) while B is valid throughout -> s_b_ready=0 until 0x03 transfers, then B is granted next.
REQ-030 Bench SHALL hold m_ready=0 for 4 cycles with a beat 0x5A held -> m_data stays 0x5A, both readies are 0, and no beat is lost when m_ready returns to 1.
REQ-031 Bench SHALL force pkt_count to 0xFFFF via 65535 packets, then send one more 1-beat packet -> pkt_count=0x0000.
REQ-032 Bench SHALL assert rst_n=0 mid-packet in LOCK_B -> m_valid=0 immediately; after release, A wins the first tie.
